// File: rtl/memstage_if.sv
// Bexkat1 memory-stage bus interface.
// Single-outstanding classic bus cycle: cyc/stb/we/adr/sel/data, ack/err.
interface memstage_if;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] adr;
   logic [3:0]  sel;
   logic [31:0] dat_w;
   logic [31:0] dat_r;
   logic        ack;
   logic        err;

   modport master (
      output cyc, stb, we, adr, sel, dat_w,
      input  dat_r, ack, err
   );

   modport slave (
      input  cyc, stb, we, adr, sel, dat_w,
      output dat_r, ack, err
   );
endinterface

// File: rtl/memstage.sv
// Bexkat1 pipeline memory stage: load/store/push/pop bus master.
// Instruction type is ir[63:60], op is ir[59:56].
module memstage #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [63:0] ir_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] result_i,
   input  logic [31:0] reg_data1_i,
   input  logic [1:0]  reg_write_i,
   input  logic [1:0]  sp_write_i,
   input  logic [31:0] sp_data_i,
   input  logic        exc_i,
   input  logic        stall_i,
   output logic        stall_o,
   output logic [63:0] ir_o,
   output logic [31:0] result_o,
   output logic [1:0]  reg_write_o,
   output logic [1:0]  sp_write_o,
   output logic [31:0] sp_data_o,
   output logic        fault_o,
   memstage_if.master  bus
);
   localparam logic [3:0] T_PUSH  = 4'd1;
   localparam logic [3:0] T_POP   = 4'd2;
   localparam logic [3:0] T_LOAD  = 4'd10;
   localparam logic [3:0] T_STORE = 4'd11;
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic {S_IDLE, S_BUS} state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_rd;
   logic [63:0]   r_ir;
   logic [31:0]   r_result;
   logic [1:0]    r_regw;
   logic [1:0]    r_spw;
   logic [31:0]   r_spd;
   logic          r_fault;
   logic          r_cyc;
   logic          r_stb;
   logic          r_we;
   logic [31:0]   r_adr;
   logic [3:0]    r_sel;
   logic [31:0]   r_dat;

   logic [3:0]  w_type;
   logic [3:0]  w_op;
   logic        w_ld;
   logic        w_st;
   logic        w_push;
   logic        w_pop;
   logic        w_mem;
   logic        w_we;
   logic [1:0]  w_size;
   logic [31:0] w_adr;
   logic [31:0] w_dat;
   logic [3:0]  w_sel;
   logic        w_mis;
   logic [31:0] w_ldat;

   assign w_type = ir_i[63:60];
   assign w_op   = ir_i[59:56];
   // exception push overrides whatever the instruction was
   assign w_push = exc_i || (w_type == T_PUSH);
   assign w_pop  = !exc_i && (w_type == T_POP);
   assign w_ld   = !exc_i && (w_type == T_LOAD);
   assign w_st   = !exc_i && (w_type == T_STORE);
   assign w_mem  = w_push || w_pop || w_ld || w_st;
   assign w_we   = w_st || w_push;

   always_comb begin
      w_size = 2'd0;
      w_adr  = result_i;
      w_dat  = reg_data1_i;
      unique case (1'b1)
         w_push: begin
            w_adr = sp_data_i;
            if (exc_i || (w_op != 4'd0))
               w_dat = pc_i;
         end
         w_pop: w_adr = sp_data_i - 32'd4;
         w_ld, w_st: begin
            w_size = (w_op[1:0] == 2'd3) ? 2'd0 : w_op[1:0];
            unique case (w_op[1:0])
               2'd1:    w_dat = {2{reg_data1_i[15:0]}};
               2'd2:    w_dat = {4{reg_data1_i[7:0]}};
               default: w_dat = reg_data1_i;
            endcase
         end
         default: ;
      endcase
   end

   // size: 0 word, 1 halfword, 2 byte; lanes are big-endian
   always_comb begin
      w_sel = 4'b1111;
      w_mis = 1'b0;
      unique case (w_size)
         2'd1: begin
            w_sel = w_adr[1] ? 4'b0011 : 4'b1100;
            w_mis = w_adr[0];
         end
         2'd2:    w_sel = 4'b1000 >> w_adr[1:0];
         default: w_mis = (w_adr[1:0] != 2'b00);
      endcase
   end

   always_comb begin
      w_ldat = bus.dat_r;
      case (r_sel)
         4'b1000: w_ldat = {24'd0, bus.dat_r[31:24]};
         4'b0100: w_ldat = {24'd0, bus.dat_r[23:16]};
         4'b0010: w_ldat = {24'd0, bus.dat_r[15:8]};
         4'b0001: w_ldat = {24'd0, bus.dat_r[7:0]};
         4'b1100: w_ldat = {16'd0, bus.dat_r[31:16]};
         4'b0011: w_ldat = {16'd0, bus.dat_r[15:0]};
         default: w_ldat = bus.dat_r;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_rd     <= 1'b0;
         r_ir     <= '0;
         r_result <= '0;
         r_regw   <= '0;
         r_spw    <= '0;
         r_spd    <= '0;
         r_fault  <= 1'b0;
         r_cyc    <= 1'b0;
         r_stb    <= 1'b0;
         r_we     <= 1'b0;
         r_adr    <= '0;
         r_sel    <= '0;
         r_dat    <= '0;
      end else begin
         r_fault <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (!stall_i) begin
                  r_ir     <= ir_i;
                  r_result <= result_i;
                  r_regw   <= reg_write_i;
                  r_spw    <= sp_write_i;
                  r_spd    <= sp_data_i;
                  if (w_mem && w_mis) begin
                     r_fault <= 1'b1;
                     r_regw  <= '0;
                     r_spw   <= '0;
                  end else if (w_mem) begin
                     r_state <= S_BUS;
                     r_cnt   <= '0;
                     r_cyc   <= 1'b1;
                     r_stb   <= 1'b1;
                     r_we    <= w_we;
                     r_adr   <= w_adr;
                     r_sel   <= w_sel;
                     r_dat   <= w_dat;
                     r_rd    <= w_ld || w_pop;
                  end
               end
            end
            S_BUS: begin
               if (bus.err || (r_cnt == CW'(TIMEOUT))) begin
                  r_state <= S_IDLE;
                  r_cyc   <= 1'b0;
                  r_stb   <= 1'b0;
                  r_fault <= 1'b1;
                  r_regw  <= '0;
                  r_spw   <= '0;
               end else if (bus.ack) begin
                  r_state <= S_IDLE;
                  r_cyc   <= 1'b0;
                  r_stb   <= 1'b0;
                  if (r_rd)
                     r_result <= w_ldat;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign stall_o     = ((r_state == S_BUS) && !bus.ack) || stall_i;
   assign ir_o        = r_ir;
   assign result_o    = r_result;
   assign reg_write_o = r_regw;
   assign sp_write_o  = r_spw;
   assign sp_data_o   = r_spd;
   assign fault_o     = r_fault;
   assign bus.cyc     = r_cyc;
   assign bus.stb     = r_stb;
   assign bus.we      = r_we;
   assign bus.adr     = r_adr;
   assign bus.sel     = r_sel;
   assign bus.dat_w   = r_dat;
endmodule

// File: tb/tb_memstage.sv
// Scoreboard bench for memstage: driver, bus slave and writeback monitor
// run as separate processes against a byte-level reference model.
module tb_memstage;
   localparam logic [3:0] T_PUSH  = 4'd1;
   localparam logic [3:0] T_POP   = 4'd2;
   localparam logic [3:0] T_LOAD  = 4'd10;
   localparam logic [3:0] T_STORE = 4'd11;

   typedef struct {
      logic [63:0] ir;
      logic [31:0] pc, res, rd1, spd;
      logic [1:0]  rw, spw;
      logic        exc;
   } stim_t;

   typedef struct {
      int          lat;
      bit          err, ack_too, none;
      logic [31:0] rdat;
   } resp_t;

   typedef struct {
      logic [31:0] adr;
      logic [3:0]  sel;
      logic        we;
      logic [31:0] dat;
   } breq_t;

   typedef struct {
      logic [63:0] ir;
      logic [31:0] res;
      logic [1:0]  rw, spw;
      logic [31:0] spd;
      logic        fault;
   } wb_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_i;
   logic [63:0] ir_i;
   logic [31:0] pc_i, result_i, reg_data1_i, sp_data_i;
   logic [1:0]  reg_write_i, sp_write_i;
   logic        exc_i, stall_i;
   logic        stall_o;
   logic [63:0] ir_o;
   logic [31:0] result_o, sp_data_o;
   logic [1:0]  reg_write_o, sp_write_o;
   logic        fault_o;

   memstage_if bus();

   memstage dut (
      .clk_i(clk), .rst_i(rst_i), .ir_i(ir_i), .pc_i(pc_i),
      .result_i(result_i), .reg_data1_i(reg_data1_i),
      .reg_write_i(reg_write_i), .sp_write_i(sp_write_i),
      .sp_data_i(sp_data_i), .exc_i(exc_i), .stall_i(stall_i),
      .stall_o(stall_o), .ir_o(ir_o), .result_o(result_o),
      .reg_write_o(reg_write_o), .sp_write_o(sp_write_o),
      .sp_data_o(sp_data_o), .fault_o(fault_o), .bus(bus)
   );

   breq_t bus_q[$];
   resp_t resp_q[$];
   wb_t   wb_q[$];
   int    issued = 0;
   int    done = 0;
   int    n_vec = 0;
   int    n_err = 0;
   int    last_hold = -1;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference: decode the access, then work in bytes and lanes.
   function automatic void model(input stim_t s, input resp_t r,
                                 output bit hb, output breq_t b,
                                 output wb_t w);
      logic [3:0]  ty, op;
      logic [31:0] a, m;
      int kind, nb, off;
      ty = s.ir[63:60];
      op = s.ir[59:56];
      w.ir = s.ir; w.res = s.res; w.rw = s.rw;
      w.spw = s.spw; w.spd = s.spd; w.fault = 1'b0;
      hb = 1'b0;
      b.adr = '0; b.sel = '0; b.we = 1'b0; b.dat = '0;
      kind = 0;
      if (s.exc) kind = 3;
      else if (ty == T_LOAD) kind = 1;
      else if (ty == T_STORE) kind = 2;
      else if (ty == T_PUSH) kind = 3;
      else if (ty == T_POP) kind = 4;
      if (kind == 0) return;
      nb = 4;
      a = s.spd;
      if (kind <= 2) begin
         a = s.res;
         nb = (op[1:0] == 2'd1) ? 2 : (op[1:0] == 2'd2) ? 1 : 4;
      end
      if (kind == 4) a = s.spd - 32'd4;
      off = int'(a[1:0]);
      m = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
      if (off % nb != 0) begin
         w.fault = 1'b1; w.rw = '0; w.spw = '0;
         return;
      end
      hb = 1'b1;
      b.adr = a;
      b.we = (kind == 2) || (kind == 3);
      for (int i = 0; i < nb; i++) b.sel[3 - off - i] = 1'b1;
      if (kind == 2)
         for (int i = 0; i < 4 / nb; i++)
            b.dat = b.dat | ((s.rd1 & m) << (8 * nb * i));
      if (kind == 3) b.dat = (s.exc || op != 4'd0) ? s.pc : s.rd1;
      if (r.err || r.none) begin
         w.fault = 1'b1; w.rw = '0; w.spw = '0;
      end else if (kind == 1 || kind == 4) begin
         w.res = (r.rdat >> (8 * (4 - off - nb))) & m;
      end
   endfunction

   task automatic drive(input stim_t s);
      ir_i = s.ir; pc_i = s.pc; result_i = s.res;
      reg_data1_i = s.rd1; sp_data_i = s.spd;
      reg_write_i = s.rw; sp_write_i = s.spw; exc_i = s.exc;
   endtask

   function automatic stim_t mk(input logic [3:0] ty, input logic [3:0] op,
                                input logic [31:0] res, input logic [31:0] rd1,
                                input logic [31:0] spd, input logic [31:0] pc);
      stim_t s;
      s.ir = {ty, op, 24'h5A5A5A, 32'h0BAD_F00D};
      s.pc = pc; s.res = res; s.rd1 = rd1; s.spd = spd;
      s.rw = 2'b01; s.spw = 2'b10; s.exc = 1'b0;
      return s;
   endfunction

   function automatic stim_t nop();
      return '{ir: 64'd0, pc: 32'd0, res: 32'd0, rd1: 32'd0,
               spd: 32'd0, rw: 2'd0, spw: 2'd0, exc: 1'b0};
   endfunction

   function automatic stim_t gen();
      stim_t s;
      logic [3:0] alu_t[9] = '{4'd0, 4'd3, 4'd4, 4'd5, 4'd6,
                               4'd9, 4'd12, 4'd13, 4'd14};
      logic [3:0] t;
      int k;
      k = $urandom_range(0, 6);
      s.pc = $urandom; s.res = $urandom; s.rd1 = $urandom;
      s.spd = $urandom; s.rw = 2'($urandom); s.spw = 2'($urandom);
      s.exc = 1'b0;
      if ($urandom_range(0, 3) != 0) begin
         s.res[1:0] = 2'b00;
         s.spd[1:0] = 2'b00;
      end
      unique case (k)
         2:       t = T_LOAD;
         3:       t = T_STORE;
         4:       t = T_PUSH;
         5:       t = T_POP;
         6: begin t = 4'($urandom); s.exc = 1'b1; end
         default: t = alu_t[$urandom_range(0, 8)];
      endcase
      s.ir = {t, 4'($urandom), 24'($urandom), 32'($urandom)};
      return s;
   endfunction

   function automatic resp_t rgen();
      resp_t r;
      r.lat = $urandom_range(0, 4);
      r.err = ($urandom_range(0, 7) == 0);
      r.ack_too = r.err && ($urandom_range(0, 1) == 1);
      r.none = 1'b0;
      r.rdat = $urandom;
      return r;
   endfunction

   task automatic summary_fatal(input string why);
      n_err++;
      $display("FAIL %s: transaction never completed", why);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1, "aborted");
   endtask

   task automatic issue(input stim_t s, input resp_t r, input bit hold,
                        output int nstall);
      bit hb;
      breq_t b;
      wb_t w;
      int t;
      model(s, r, hb, b, w);
      if (hb) begin
         bus_q.push_back(b);
         resp_q.push_back(r);
      end
      wb_q.push_back(w);
      @(negedge clk);
      drive(s);
      stall_i = 1'b0;
      @(posedge clk);
      #1;
      issued++;
      if (hold) begin
         stall_i = 1'b1;
         drive(gen());
      end else begin
         drive(nop());
      end
      nstall = 0;
      t = 0;
      while (done != issued && t < 600) begin
         @(negedge clk);
         #2;
         if (done != issued && stall_o) nstall++;
         t++;
      end
      if (done != issued) summary_fatal("wb_wait");
      if (hold) begin
         repeat (2) @(negedge clk);
         #2;
         chk("hold_ir", ir_o, w.ir);
         chk("hold_result", result_o, w.res);
         chk("hold_fault", fault_o, 1'b0);
      end
   endtask

   initial begin : slave
      bit busy;
      int wn, hold;
      resp_t cur;
      breq_t eb;
      busy = 0; wn = 0; hold = 0;
      cur = '{lat: 0, err: 0, ack_too: 0, none: 0, rdat: 0};
      bus.ack = 1'b0; bus.err = 1'b0; bus.dat_r = '0;
      forever begin
         @(negedge clk);
         bus.ack = 1'b0;
         bus.err = 1'b0;
         bus.dat_r = $urandom;
         if (bus.cyc && bus.stb) begin
            if (!busy) begin
               busy = 1;
               hold = 0;
               if (resp_q.size() == 0 || bus_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL bus_cycle: got adr %h expected no cycle",
                           bus.adr);
                  cur = '{lat: 0, err: 0, ack_too: 0, none: 0, rdat: 0};
               end else begin
                  cur = resp_q.pop_front();
                  eb = bus_q.pop_front();
                  chk("bus_adr", bus.adr, eb.adr);
                  chk("bus_sel", bus.sel, eb.sel);
                  chk("bus_we", bus.we, eb.we);
                  if (eb.we) chk("bus_dat", bus.dat_w, eb.dat);
               end
               wn = cur.lat;
            end
            hold++;
            if (!cur.none) begin
               if (wn == 0) begin
                  bus.err = cur.err;
                  bus.ack = !cur.err || cur.ack_too;
                  bus.dat_r = cur.rdat;
                  busy = 0;
               end else begin
                  wn--;
               end
            end
         end else if (busy) begin
            last_hold = hold;
            busy = 0;
         end
      end
   end

   initial begin : monitor
      wb_t e;
      forever begin
         @(negedge clk);
         #1;
         if (issued > done && !bus.cyc) begin
            if (wb_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL wb_queue: got output expected none");
            end else begin
               e = wb_q.pop_front();
               chk("ir_o", ir_o, e.ir);
               chk("result_o", result_o, e.res);
               chk("reg_write_o", reg_write_o, e.rw);
               chk("sp_write_o", sp_write_o, e.spw);
               chk("sp_data_o", sp_data_o, e.spd);
               chk("fault_o", fault_o, e.fault);
            end
            done++;
         end
      end
   end

   initial begin : watchdog
      #1ms;
      summary_fatal("watchdog");
   end

   initial begin : driver
      stim_t s;
      resp_t r;
      breq_t b;
      wb_t w;
      bit hb;
      int ns;
      rst_i = 1'b1;
      stall_i = 1'b0;
      drive(nop());
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cyc", bus.cyc, 1'b0);
      chk("rst_stb", bus.stb, 1'b0);
      chk("rst_result", result_o, 32'd0);
      chk("rst_ir", ir_o, 64'd0);
      chk("rst_fault", fault_o, 1'b0);
      chk("rst_stall", stall_o, 1'b0);
      rst_i = 1'b0;

      r = '{lat: 0, err: 0, ack_too: 0, none: 0, rdat: 32'h0};
      s = mk(4'd5, 4'd0, 32'h1234, 32'h0, 32'h0, 32'h0);
      issue(s, r, 1'b0, ns);
      chk("t1_nstall", ns, 0);
      chk("t1_result", result_o, 32'h1234);

      r = '{lat: 3, err: 0, ack_too: 0, none: 0, rdat: 32'hAABBCCDD};
      s = mk(T_LOAD, 4'd2, 32'h102, 32'h0, 32'h0, 32'h0);
      issue(s, r, 1'b0, ns);
      chk("t2_nstall", ns, 3);
      chk("t2_result", result_o, 32'h0000_00CC);

      r = '{lat: 1, err: 0, ack_too: 0, none: 0, rdat: 32'h0};
      s = mk(T_STORE, 4'd1, 32'h200, 32'h0000_BEEF, 32'h0, 32'h0);
      issue(s, r, 1'b1, ns);

      r = '{lat: 0, err: 0, ack_too: 0, none: 0, rdat: 32'h1357_9BDF};
      s = mk(T_POP, 4'd0, 32'h0, 32'h0, 32'h1000, 32'h0);
      issue(s, r, 1'b0, ns);
      s = mk(T_PUSH, 4'd1, 32'h77, 32'h1111_2222, 32'h2000, 32'h4444);
      issue(s, r, 1'b0, ns);

      s = mk(T_LOAD, 4'd0, 32'h102, 32'h0, 32'h0, 32'h0);
      issue(s, r, 1'b0, ns);

      r = '{lat: 0, err: 0, ack_too: 0, none: 1, rdat: 32'h0};
      s = mk(T_LOAD, 4'd3, 32'h400, 32'h0, 32'h0, 32'h0);
      issue(s, r, 1'b0, ns);
      chk("timeout_len", (last_hold >= 255 && last_hold <= 256), 1'b1);
      chk("timeout_regw", reg_write_o, 2'd0);

      r = '{lat: 1, err: 1, ack_too: 1, none: 0, rdat: 32'h0};
      issue(s, r, 1'b0, ns);
      chk("err_regw", reg_write_o, 2'd0);

      r = '{lat: 0, err: 0, ack_too: 0, none: 1, rdat: 32'h0};
      s = mk(T_LOAD, 4'd0, 32'h300, 32'h0, 32'h0, 32'h0);
      model(s, r, hb, b, w);
      bus_q.push_back(b);
      resp_q.push_back(r);
      @(negedge clk);
      drive(s);
      @(posedge clk);
      #1;
      drive(nop());
      repeat (4) @(negedge clk);
      #1;
      chk("pre_rst_cyc", bus.cyc, 1'b1);
      rst_i = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_cyc", bus.cyc, 1'b0);
      chk("mid_rst_stb", bus.stb, 1'b0);
      chk("mid_rst_ir", ir_o, 64'd0);
      chk("mid_rst_regw", reg_write_o, 2'd0);
      chk("mid_rst_stall", stall_o, 1'b0);
      @(negedge clk);
      rst_i = 1'b0;

      for (int i = 0; i < 150; i++)
         issue(gen(), rgen(), ($urandom_range(0, 2) == 0), ns);

      repeat (3) @(negedge clk);
      chk("bus_q_empty", bus_q.size(), 0);
      chk("wb_q_empty", wb_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
